fb_access_arbiter: RTL

//  Shares the single-port 32-bit-word framebuffer RAM between two requesters:
//  - the VGA scan-out fetcher, which has priority;
//  - host pixel writes from the Avalon slave, queued in a small write FIFO.

---
 rtl/fb_access_arbiter_if.sv | 40 ++++
 rtl/fb_access_arbiter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/fb_access_arbiter_if.sv
// Signal bundle for the framebuffer arbiter: host write queue port, scan fetch port,
// single-port RAM command port and status counters.
interface fb_access_arbiter_if #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic [CNT_W-1:0]  fifo_count;
  logic [15:0]       starve_events;

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_req, rd_addr, mem_rdata,
    output wr_ready, rd_gnt, rd_valid, rd_data, mem_addr, mem_we, mem_wdata,
           fifo_count, starve_events
  );

  modport master (
    output wr_valid, wr_addr, wr_data, rd_req, rd_addr, mem_rdata,
    input  wr_ready, rd_gnt, rd_valid, rd_data, mem_addr, mem_we, mem_wdata,
           fifo_count, starve_events
  );
endinterface

// File: rtl/fb_access_arbiter.sv
// Single-port framebuffer arbiter: scan-out reads have priority over queued host writes,
// with a starvation counter that forces a queued write through after STARVE_MAX lost cycles.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no memory command issued last cycle
// RD    | scan fetch granted last cycle
// WR    | queued host write issued last cycle (no competing read)
// FWR   | queued host write forced through, scan fetch held off
module fb_access_arbiter #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int STARVE_MAX = 15
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  fb_access_arbiter_if.slave    bus,
  output logic [1:0]            o_state
);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int SCNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_FWR  = 2'd3
  } grant_t;

  logic [ADDR_W-1:0] r_q_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] r_q_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic [SCNT_W-1:0] r_starve_cnt;
  logic [15:0]       r_starve_events;
  grant_t            r_state;

  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_we;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_rd_p1;
  logic              r_rd_p2;

  grant_t            w_gnt;
  logic              w_empty;
  logic              w_full;
  logic              w_wr_ready;
  logic              w_push;
  logic              w_pop;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
  // Readiness comes only from the registered count, so a full queue refuses
  // a push even in the cycle it pops.
  assign w_wr_ready = !i_reset && !w_full;
  assign w_push     = bus.wr_valid && w_wr_ready;

  always_comb begin
    w_gnt = S_IDLE;
    if (!w_empty && (r_starve_cnt == SCNT_W'(STARVE_MAX)))
      w_gnt = S_FWR;
    else if (bus.rd_req)
      w_gnt = S_RD;
    else if (!w_empty)
      w_gnt = S_WR;
  end

  assign w_pop = (w_gnt == S_WR) || (w_gnt == S_FWR);

  // Queue storage needs no reset; occupancy is defined by the pointers alone.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_q_addr[r_wptr] <= bus.wr_addr;
      r_q_data[r_wptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wptr          <= '0;
      r_rptr          <= '0;
      r_count         <= '0;
      r_starve_cnt    <= '0;
      r_starve_events <= '0;
      r_state         <= S_IDLE;
      r_mem_addr      <= '0;
      r_mem_we        <= 1'b0;
      r_mem_wdata     <= '0;
      r_rd_p1         <= 1'b0;
      r_rd_p2         <= 1'b0;
    end else begin
      r_state <= w_gnt;

      if (w_push)
        r_wptr <= r_wptr + 1'b1;
      if (w_pop)
        r_rptr <= r_rptr + 1'b1;

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      if (w_empty || w_pop)
        r_starve_cnt <= '0;
      else if ((w_gnt == S_RD) && (r_starve_cnt < SCNT_W'(STARVE_MAX)))
        r_starve_cnt <= r_starve_cnt + 1'b1;

      if ((w_gnt == S_FWR) && (r_starve_events != 16'hFFFF))
        r_starve_events <= r_starve_events + 16'd1;

      case (w_gnt)
        S_RD: begin
          r_mem_addr <= bus.rd_addr;
          r_mem_we   <= 1'b0;
        end
        S_WR, S_FWR: begin
          r_mem_addr  <= r_q_addr[r_rptr];
          r_mem_wdata <= r_q_data[r_rptr];
          r_mem_we    <= 1'b1;
        end
        default: r_mem_we <= 1'b0;
      endcase

      // RAM returns data one cycle after the registered address, so the
      // grant is delayed two cycles to line up with mem_rdata.
      r_rd_p1 <= (w_gnt == S_RD);
      r_rd_p2 <= r_rd_p1;
    end
  end

  assign bus.wr_ready      = w_wr_ready;
  assign bus.rd_gnt        = (w_gnt == S_RD) && !i_reset;
  assign bus.rd_valid      = r_rd_p2;
  assign bus.rd_data       = bus.mem_rdata;
  assign bus.mem_addr      = r_mem_addr;
  assign bus.mem_we        = r_mem_we;
  assign bus.mem_wdata     = r_mem_wdata;
  assign bus.fifo_count    = r_count;
  assign bus.starve_events = r_starve_events;
  assign o_state           = r_state;
endmodule
